// File: rtl/ahb3_master.sv
// AHB-Lite initiator: turns a command/response front end into pipelined SINGLE/INCR transfers.
// Optional build macro AHB3_MASTER_ERR_ABORT_EN cancels the rest of a burst on the first ERROR cycle.
module ahb3_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_last,
   output logic              hsel,
   output logic [ADDR_W-1:0] haddr,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [3:0]        hprot,
   output logic [1:0]        htrans,
   output logic              hmastlock,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;
   localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_W/8));

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   haddr_q, haddr_d;
   logic [1:0]          htrans_q, htrans_d;
   logic                hwrite_q, hwrite_d;
   logic [2:0]          hsize_q, hsize_d;
   logic [2:0]          hburst_q, hburst_d;
   logic [DATA_W-1:0]   hwdata_q, hwdata_d;
   logic                hsel_q, hsel_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic [LEN_W-1:0]    beats_left_q, beats_left_d;
   logic                dp_valid_q, dp_valid_d;
   logic                dp_last_q, dp_last_d;
   logic                dp_write_q, dp_write_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_last_q, rsp_last_d;
   logic [ADDR_W-1:0]   next_addr;
   logic                trans_act;

   assign trans_act = htrans_q[1];
   assign next_addr = haddr_q + (ADDR_W'(1) << hsize_q);

   always_comb begin
      state_d      = state_q;
      haddr_d      = haddr_q;
      htrans_d     = htrans_q;
      hwrite_d     = hwrite_q;
      hsize_d      = hsize_q;
      hburst_d     = hburst_q;
      hwdata_d     = hwdata_q;
      beats_left_d = beats_left_q;
      dp_valid_d   = dp_valid_q;
      dp_last_d    = dp_last_q;
      dp_write_d   = dp_write_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_last_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d      = ST_ADDR;
               haddr_d      = cmd_addr;
               htrans_d     = HT_NONSEQ;
               hwrite_d     = cmd_write;
               hsize_d      = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
               hburst_d     = (cmd_len == '0) ? 3'b000 : 3'b001;
               beats_left_d = cmd_len;
            end
         end
         default: begin
            if (hready) begin
               if (dp_valid_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = dp_write_q ? '0 : hrdata;
                  rsp_err_d   = hresp;
                  rsp_last_d  = dp_last_q;
               end
               dp_valid_d = trans_act;
               if (trans_act) begin
                  dp_last_d  = (beats_left_q == '0);
                  dp_write_d = hwrite_q;
                  if (hwrite_q) hwdata_d = wr_data;
                  if (beats_left_q != '0) begin
                     haddr_d      = next_addr;
                     // a burst may not cross a 1KB page, so restart it there
                     htrans_d     = (next_addr[ADDR_W-1:10] != haddr_q[ADDR_W-1:10]) ? HT_NONSEQ : HT_SEQ;
                     beats_left_d = beats_left_q - LEN_W'(1);
                  end else begin
                     htrans_d = HT_IDLE;
                     state_d  = ST_DATA;
                  end
               end else if (state_q == ST_DATA && dp_valid_q) begin
                  state_d = ST_IDLE;
               end
            end
`ifdef AHB3_MASTER_ERR_ABORT_EN
            else if (hresp && dp_valid_q) begin
               htrans_d     = HT_IDLE;
               beats_left_d = '0;
               dp_last_d    = 1'b1;
               state_d      = ST_DATA;
            end
`endif
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      hsel_d      = htrans_d[1] | dp_valid_d;
   end

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state_q      <= ST_IDLE;
         haddr_q      <= '0;
         htrans_q     <= HT_IDLE;
         hwrite_q     <= 1'b0;
         hsize_q      <= '0;
         hburst_q     <= '0;
         hwdata_q     <= '0;
         hsel_q       <= 1'b0;
         cmd_ready_q  <= 1'b0;
         beats_left_q <= '0;
         dp_valid_q   <= 1'b0;
         dp_last_q    <= 1'b0;
         dp_write_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         haddr_q      <= haddr_d;
         htrans_q     <= htrans_d;
         hwrite_q     <= hwrite_d;
         hsize_q      <= hsize_d;
         hburst_q     <= hburst_d;
         hwdata_q     <= hwdata_d;
         hsel_q       <= hsel_d;
         cmd_ready_q  <= cmd_ready_d;
         beats_left_q <= beats_left_d;
         dp_valid_q   <= dp_valid_d;
         dp_last_q    <= dp_last_d;
         dp_write_q   <= dp_write_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         rsp_last_q   <= rsp_last_d;
      end
   end

   // the write beat is popped only on the edge that accepts its address phase
   assign wr_ready  = trans_act & hwrite_q & hready;
   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_last  = rsp_last_q;
   assign hsel      = hsel_q;
   assign haddr     = haddr_q;
   assign hwrite    = hwrite_q;
   assign hsize     = hsize_q;
   assign hburst    = hburst_q;
   assign hprot     = 4'b0011;
   assign htrans    = htrans_q;
   assign hmastlock = 1'b0;
   assign hwdata    = hwdata_q;

endmodule
